// File: rtl/gpio_regbank_pkg.sv
// gpio_regbank_pkg
//   Shared definitions for the GPIO register bank: default register-window
//   offsets, register-select encoding and small decode helpers.
package gpio_regbank_pkg;

    localparam int unsigned OUT_OFFSET = 32'h0000_1000;
    localparam int unsigned DDR_OFFSET = 32'h0000_1100;
    localparam int unsigned IN_OFFSET  = 32'h0000_1200;
    localparam int unsigned REG_STRIDE = 4;

    typedef enum logic [1:0] {
        SEL_OUT,
        SEL_DDR,
        SEL_IN,
        SEL_NONE
    } reg_sel_e;

    // Number of BusWidth-wide registers needed to cover all pins.
    function automatic int unsigned num_reg(input int unsigned pins, input int unsigned width);
        return (pins + width - 1) / width;
    endfunction

    // Register index inside a window. An address below the base wraps to a
    // huge value, so a single "< NumReg" test rejects both sides of the window.
    function automatic int unsigned reg_index(input int unsigned addr, input int unsigned base);
        return (addr - base) / REG_STRIDE;
    endfunction

endpackage

// File: rtl/gpio_sync_chain.sv
// gpio_sync_chain
//   Multi-flop synchroniser for asynchronous pad inputs.
//   i_clk   : sampling clock
//   i_rst_n : asynchronous active-low reset, clears every stage
//   i_d     : asynchronous input bits
//   o_q     : synchronised bits (last stage)
module gpio_sync_chain #(
    parameter int Width  = 32,
    parameter int Stages = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Stages-1:0][Width-1:0] r_stage;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: every stage is reset so a read right after reset returns 0, not stale pad data.
            r_stage <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes its neighbour's pre-edge value (a true shift).
            r_stage[0] <= i_d;
            for (int s = 1; s < Stages; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_q = r_stage[Stages-1];

endmodule

// File: rtl/gpio_regbank_ddr.sv
// gpio_regbank_ddr
//   GPIO register bank: per-pin OUT and DDR (1 = output) registers with
//   byte-enabled writes, synchronised IN registers, registered 1-cycle read-back.
//   CLOCK, reset_reg_N           : clock, asynchronous active-low reset
//   address/write/writedata/byteenable/read : bus request
//   readdata/readdatavalid       : read response, one cycle after read
//   gpio_in                      : asynchronous pad inputs
//   gpio_out/gpio_oe             : pad output data / output enables
module gpio_regbank_ddr
    import gpio_regbank_pkg::*;
#(
    parameter int AddrWidth  = 14,
    parameter int BusWidth   = 32,
    parameter int NumPins    = 144,
    parameter int OutBase    = OUT_OFFSET,
    parameter int DdrBase    = DDR_OFFSET,
    parameter int InBase     = IN_OFFSET,
    parameter int SyncStages = 2
) (
    input  logic                  CLOCK,
    input  logic                  reset_reg_N,
    input  logic [AddrWidth-1:0]  address,
    input  logic                  write,
    input  logic [BusWidth-1:0]   writedata,
    input  logic [BusWidth/8-1:0] byteenable,
    input  logic                  read,
    output logic [BusWidth-1:0]   readdata,
    output logic                  readdatavalid,
    input  logic [NumPins-1:0]    gpio_in,
    output logic [NumPins-1:0]    gpio_out,
    output logic [NumPins-1:0]    gpio_oe
);

    localparam int NumReg   = num_reg(NumPins, BusWidth);
    localparam int PadWidth = NumReg * BusWidth;
    localparam int IdxWidth = (NumReg > 1) ? $clog2(NumReg) : 1;

    logic [NumPins-1:0]  r_out;
    logic [NumPins-1:0]  r_ddr;
    logic [NumPins-1:0]  w_in_pins;
    logic [BusWidth-1:0] r_rdata;
    logic                r_rvalid;

    reg_sel_e            w_sel;
    logic [IdxWidth-1:0] w_idx;
    int unsigned         w_addr;
    logic [NumPins-1:0]  w_pin_en;
    logic [NumPins-1:0]  w_pin_data;
    logic [NumPins-1:0]  w_out_en;
    logic [NumPins-1:0]  w_ddr_en;
    logic [PadWidth-1:0] w_out_pad;
    logic [PadWidth-1:0] w_ddr_pad;
    logic [PadWidth-1:0] w_in_pad;
    logic [BusWidth-1:0] w_rd_word;

    // Input synchronisers, one chain per register-sized bank of pins.
    for (genvar g = 0; g < NumReg; g++) begin : g_bank
        localparam int W = (g == NumReg - 1) ? NumPins - g * BusWidth : BusWidth;
        gpio_sync_chain #(
            .Width  (W),
            .Stages (SyncStages)
        ) u_sync (
            .i_clk   (CLOCK),
            .i_rst_n (reset_reg_N),
            .i_d     (gpio_in[g*BusWidth +: W]),
            .o_q     (w_in_pins[g*BusWidth +: W])
        );
    end

    // Address decode: aligned and inside one of the three windows.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_sel  = SEL_NONE;
        w_idx  = '0;
        w_addr = 32'(address);
        if (address[1:0] == 2'b00) begin
            if (reg_index(w_addr, OutBase) < NumReg) begin
                w_sel = SEL_OUT;
                w_idx = IdxWidth'(reg_index(w_addr, OutBase));
            end else if (reg_index(w_addr, DdrBase) < NumReg) begin
                w_sel = SEL_DDR;
                w_idx = IdxWidth'(reg_index(w_addr, DdrBase));
            end else if (reg_index(w_addr, InBase) < NumReg) begin
                w_sel = SEL_IN;
                w_idx = IdxWidth'(reg_index(w_addr, InBase));
            end
        end
    end

    // Per-pin write enable: pin lives in the addressed register and its byte lane is enabled.
    // Pins beyond NumPins simply have no flop, so their write bits fall away.
    always_comb begin
        w_pin_en   = '0;
        w_pin_data = '0;
        for (int p = 0; p < NumPins; p++) begin
            w_pin_en[p]   = write && (w_idx == IdxWidth'(p / BusWidth))
                            && byteenable[(p % BusWidth) / 8];
            w_pin_data[p] = writedata[p % BusWidth];
        end
    end

    assign w_out_en = w_pin_en & {NumPins{w_sel == SEL_OUT}};
    assign w_ddr_en = w_pin_en & {NumPins{w_sel == SEL_DDR}};

    always_ff @(posedge CLOCK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_out <= '0;
            r_ddr <= '0;
        end else begin
            r_out <= (r_out & ~w_out_en) | (w_pin_data & w_out_en);
            r_ddr <= (r_ddr & ~w_ddr_en) | (w_pin_data & w_ddr_en);
        end
    end

    // Zero-extend to whole registers so unused top bits of the last one read 0.
    assign w_out_pad = PadWidth'(r_out);
    assign w_ddr_pad = PadWidth'(r_ddr);
    assign w_in_pad  = PadWidth'(w_in_pins);

    always_comb begin
        w_rd_word = '0;
        case (w_sel)
            SEL_OUT: w_rd_word = w_out_pad[w_idx*BusWidth +: BusWidth];
            SEL_DDR: w_rd_word = w_ddr_pad[w_idx*BusWidth +: BusWidth];
            SEL_IN:  w_rd_word = w_in_pad[w_idx*BusWidth +: BusWidth];
            default: w_rd_word = '0;
        endcase
    end

    // Sampled at the same edge that commits a write, so a same-cycle read sees the old value.
    always_ff @(posedge CLOCK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= read;
            if (read) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    assign readdata      = r_rdata;
    assign readdatavalid = r_rvalid;
    assign gpio_out      = r_out;
    assign gpio_oe       = r_ddr;

endmodule

// File: tb/tb_gpio_regbank_ddr.sv
// tb_gpio_regbank_ddr
//   Randomised and directed stimulus against a word-level reference model;
//   read responses are checked by a scoreboard monitor.
module tb_gpio_regbank_ddr;

    localparam int NUM_PINS = 144;
    localparam int NUM_REG  = 5;
    localparam int OUT_B    = 'h1000;
    localparam int DDR_B    = 'h1100;
    localparam int IN_B     = 'h1200;

    logic                CLOCK = 1'b0;
    logic                reset_reg_N = 1'b1;
    logic [13:0]         address = '0;
    logic                write = 1'b0;
    logic [31:0]         writedata = '0;
    logic [3:0]          byteenable = '0;
    logic                read = 1'b0;
    logic [31:0]         readdata;
    logic                readdatavalid;
    logic [NUM_PINS-1:0] gpio_in = '0;
    logic [NUM_PINS-1:0] gpio_out;
    logic [NUM_PINS-1:0] gpio_oe;

    gpio_regbank_ddr dut (
        .CLOCK         (CLOCK),
        .reset_reg_N   (reset_reg_N),
        .address       (address),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .gpio_in       (gpio_in),
        .gpio_out      (gpio_out),
        .gpio_oe       (gpio_oe)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: one word per register plus the pad-input history.
    logic [31:0]         m_out [NUM_REG];
    logic [31:0]         m_ddr [NUM_REG];
    logic [NUM_PINS-1:0] pin_cur, hist1, hist2;
    logic [31:0]         exp_q [$];
    logic [31:0]         exp_hold;
    int                  checks = 0;
    int                  failures = 0;
    bit                  mon_en = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input int idx);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 32; b++) if (idx * 32 + b < NUM_PINS) m[b] = 1'b1;
        return m;
    endfunction

    // region: 0 miss, 1 OUT, 2 DDR, 3 IN
    task automatic decode(input int addr, output int region, output int idx);
        int bases [3];
        bases = '{OUT_B, DDR_B, IN_B};
        region = 0;
        idx = 0;
        if (addr % 4 == 0) begin
            for (int k = 0; k < 3; k++) begin
                if (addr >= bases[k] && addr < bases[k] + 4 * NUM_REG) begin
                    region = k + 1;
                    idx = (addr - bases[k]) / 4;
                end
            end
        end
    endtask

    task automatic model_read(input int addr, output logic [31:0] val);
        int region, idx;
        logic [159:0] pad;
        decode(addr, region, idx);
        pad = 160'(hist2);
        case (region)
            1:       val = m_out[idx];
            2:       val = m_ddr[idx];
            3:       val = pad[idx*32 +: 32];
            default: val = 32'h0;
        endcase
    endtask

    function automatic logic [NUM_PINS-1:0] flat(input bit is_ddr);
        logic [NUM_PINS-1:0] v;
        logic [31:0] w;
        for (int p = 0; p < NUM_PINS; p++) begin
            w = is_ddr ? m_ddr[p / 32] : m_out[p / 32];
            v[p] = w[p % 32];
        end
        return v;
    endfunction

    // One bus cycle; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input logic w, input logic r, input int addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [NUM_PINS-1:0] pins);
        logic [31:0] exp_rd, bm;
        int region, idx;
        write = w; read = r; address = addr[13:0]; writedata = wd; byteenable = be;
        gpio_in = pins; pin_cur = pins;
        model_read(addr, exp_rd);
        decode(addr, region, idx);
        @(posedge CLOCK);
        if (r) exp_q.push_back(exp_rd);
        if (w) begin
            for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{be[b]}};
            if (region == 1) m_out[idx] = ((m_out[idx] & ~bm) | (wd & bm)) & lane_mask(idx);
            if (region == 2) m_ddr[idx] = ((m_ddr[idx] & ~bm) | (wd & bm)) & lane_mask(idx);
        end
        hist2 = hist1;
        hist1 = pin_cur;
        #1;
        write = 1'b0; read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 32'h0, 4'h0, pin_cur);
    endtask

    // Asserts reset immediately, checks outputs cleared, releases at posedge+1.
    task automatic assert_reset();
        reset_reg_N = 1'b0;
        mon_en = 1'b0;
        for (int i = 0; i < NUM_REG; i++) begin
            m_out[i] = '0;
            m_ddr[i] = '0;
        end
        exp_q.delete();
        exp_hold = '0;
        #1;
        check("rst_gpio_out", gpio_out, '0);
        check("rst_gpio_oe", gpio_oe, '0);
        check("rst_rvalid", readdatavalid, '0);
        check("rst_readdata", readdata, '0);
        write = 1'b0; read = 1'b0;
        repeat (3) @(posedge CLOCK);
        #1;
        reset_reg_N = 1'b1;
        hist1 = '0;
        hist2 = '0;
        mon_en = 1'b1;
    endtask

    // Scoreboard monitor: response must appear exactly one cycle after the read.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge CLOCK);
            if (mon_en && reset_reg_N) begin
                check("gpio_out", gpio_out, flat(1'b0));
                check("gpio_oe", gpio_oe, flat(1'b1));
                check("rvalid", readdatavalid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (readdatavalid) begin
                        exp_hold = e;
                        check("readdata", readdata, e);
                    end
                end else begin
                    check("readdata_hold", readdata, exp_hold);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base_tab [4];
        int addr;
        logic [159:0] rnd;
        logic [NUM_PINS-1:0] pins;
        base_tab = '{OUT_B, DDR_B, IN_B, 'h1300};
        pin_cur = '0;
        #1;
        @(posedge CLOCK);
        #1;
        assert_reset();

        // Reset state readback.
        cycle(1'b0, 1'b1, DDR_B, 32'h0, 4'h0, '0);

        // DDR register 1, then readback.
        cycle(1'b1, 1'b0, DDR_B + 4, 32'h00FF_00FF, 4'hF, '0);
        check("oe_reg1", gpio_oe[63:32], 32'h00FF_00FF);
        cycle(1'b0, 1'b1, DDR_B + 4, 32'h0, 4'h0, '0);

        // Byte-enabled partial write.
        cycle(1'b1, 1'b0, OUT_B, 32'hAAAA_AAAA, 4'hF, '0);
        cycle(1'b1, 1'b0, OUT_B, 32'h1234_5678, 4'b0010, '0);
        cycle(1'b0, 1'b1, OUT_B, 32'h0, 4'h0, '0);

        // Last register only partly populated.
        cycle(1'b1, 1'b0, DDR_B + 16, 32'hFFFF_FFFF, 4'hF, '0);
        check("oe_top", gpio_oe[143:128], 16'hFFFF);
        cycle(1'b0, 1'b1, DDR_B + 16, 32'h0, 4'h0, '0);

        // Input synchroniser latency, ignored IN write, misses.
        idle(3);
        pins = '0;
        pins[5] = 1'b1;
        cycle(1'b0, 1'b1, IN_B, 32'h0, 4'h0, pins);
        cycle(1'b0, 1'b1, IN_B, 32'h0, 4'h0, pins);
        cycle(1'b0, 1'b1, IN_B, 32'h0, 4'h0, pins);
        cycle(1'b1, 1'b0, IN_B, 32'hFFFF_FFFF, 4'hF, pins);
        cycle(1'b0, 1'b1, IN_B, 32'h0, 4'h0, pins);
        cycle(1'b0, 1'b1, 'h1300, 32'h0, 4'h0, pins);
        cycle(1'b0, 1'b1, 'h1101, 32'h0, 4'h0, pins);

        // Same-cycle read and write.
        cycle(1'b1, 1'b0, OUT_B, 32'h1, 4'hF, pins);
        cycle(1'b1, 1'b1, OUT_B, 32'h2, 4'hF, pins);
        cycle(1'b0, 1'b1, OUT_B, 32'h0, 4'h0, pins);
        idle(1);

        // Reset in the middle of a read+write transfer.
        address = OUT_B[13:0]; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
        write = 1'b1; read = 1'b1;
        #2;
        assert_reset();
        cycle(1'b0, 1'b1, OUT_B, 32'h0, 4'h0, pins);
        idle(1);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            addr = base_tab[$urandom_range(0, 3)] + 4 * int'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) addr += int'($urandom_range(1, 3));
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            pins = ($urandom_range(0, 3) == 0) ? rnd[NUM_PINS-1:0] : pin_cur;
            case ($urandom_range(0, 3))
                0:       cycle(1'b0, 1'b0, addr, $urandom, 4'($urandom_range(0, 15)), pins);
                1:       cycle(1'b1, 1'b0, addr, $urandom, 4'($urandom_range(0, 15)), pins);
                2:       cycle(1'b0, 1'b1, addr, $urandom, 4'($urandom_range(0, 15)), pins);
                default: cycle(1'b1, 1'b1, addr, $urandom, 4'($urandom_range(0, 15)), pins);
            endcase
        end

        idle(3);
        check("queue_drained", 160'(exp_q.size()), 160'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
